// File: rtl/dm_resp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dm_resp : single-outstanding data-memory responder with wait states.
// Optional access error checking when DM_RESP_ERR_EN is defined.
// Revision: 1.0
// ---------------------------------------------------------------------------
module dm_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int c_depth = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic [31:0]           mem_q [c_depth];

  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_commit;
  logic                  w_access_err;

  assign w_idx    = addr_q[DEPTH_LOG2+1:2];
  // The access takes effect on the same edge that moves BUSY into RESP.
  assign w_commit = (state_q == BUSY) && (cnt_q == 4'd0);

`ifdef DM_RESP_ERR_EN
  logic [31:0] w_addr_hi;
  logic        w_aligned;

  always_comb begin
    w_addr_hi = addr_q >> (DEPTH_LOG2 + 2);
    w_aligned = 1'b0;
    case (be_q)
      4'b0001: w_aligned = (addr_q[1:0] == 2'd0);
      4'b0010: w_aligned = (addr_q[1:0] == 2'd1);
      4'b0100: w_aligned = (addr_q[1:0] == 2'd2);
      4'b1000: w_aligned = (addr_q[1:0] == 2'd3);
      4'b0011: w_aligned = (addr_q[1:0] == 2'd0);
      4'b1100: w_aligned = (addr_q[1:0] == 2'd2);
      4'b1111: w_aligned = (addr_q[1:0] == 2'd0);
      default: w_aligned = 1'b0;
    endcase
    w_access_err = (w_addr_hi != 32'd0) || !w_aligned;
  end
`else
  logic w_unused_addr;
  assign w_unused_addr = ^{addr_q[31:DEPTH_LOG2+2], addr_q[1:0]};
  assign w_access_err  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = BUSY;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (req_valid && req_ready) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (w_commit) begin
        rdata_q <= (!we_q && !w_access_err) ? mem_q[w_idx] : 32'd0;
        err_q   <= w_access_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < c_depth; i++) mem_q[i] <= 32'd0;
    end else if (w_commit && we_q && !w_access_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
  assign rsp_err   = rsp_valid ? err_q   : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_dm_resp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dm_resp : directed self-checking bench for dm_resp (WAIT_CYCLES 2 and 0).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_dm_resp;

`ifdef DM_RESP_ERR_EN
  localparam logic c_err_en = 1'b1;
`else
  localparam logic c_err_en = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid0 = 1'b0, req_we0 = 1'b0, rsp_ready0 = 1'b0;
  logic [31:0] req_addr0 = 32'd0, req_wdata0 = 32'd0;
  logic [3:0]  req_be0 = 4'd0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dm_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  // One complete access on u_dut; lat = edges from handshake to rsp_valid, -1 on timeout.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output logic [31:0] rdata,
                           output logic err, output int lat);
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFC;
    req_wdata = ~wdata; req_be = 4'hF;
    lat = -1;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (rsp_valid) lat = n;
    end
    rdata = rsp_rdata; err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", rsp_err); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
  endtask

  task automatic test_word_rw();
    logic [31:0] rd; logic er; int lat;
    do_access(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d want 3", lat); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL wr_rdata got %h want 0", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", er); end
    do_access(1'b0, 32'h10, 32'h0, 4'b1111, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d want 3", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", er); end
  endtask

  task automatic test_byte_lane();
    logic [31:0] rd; logic er; int lat;
    do_access(1'b1, 32'h20, 32'h11223344, 4'b1111, rd, er, lat);
    do_access(1'b1, 32'h22, 32'h00AA0000, 4'b0100, rd, er, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lane_wr_err got %b want 0", er); end
    do_access(1'b0, 32'h20, 32'h0, 4'b1111, rd, er, lat);
    checks++; if (rd !== 32'h11AA3344) begin errors++; $display("FAIL lane_rd got %h want 11aa3344", rd); end
    do_access(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL be0_latency got %0d want 3", lat); end
    checks++; if (er !== c_err_en) begin errors++; $display("FAIL be0_err got %b want %b", er, c_err_en); end
    do_access(1'b0, 32'h20, 32'h0, 4'b1111, rd, er, lat);
    checks++; if (rd !== 32'h11AA3344) begin errors++; $display("FAIL be0_noop got %h want 11aa3344", rd); end
  endtask

  task automatic test_stall();
    int seen;
    req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(posedge clk); #1;
    end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_timeout got %b want 1", rsp_valid); end
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles want 0", seen); end
    checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_rdata got %h want deadbeef", rsp_rdata); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_release got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL idle_rdata got %h want 0", rsp_rdata); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after got %b want 1", req_ready); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat; int seen;
    req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_be = 4'hF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_rsp got %0d responses want 0", seen); end
    do_access(1'b0, 32'h30, 32'h0, 4'b1111, rd, er, lat);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL abort_mem got %h want 0", rd); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL abort_lat got %0d want 3", lat); end
    do_access(1'b0, 32'h10, 32'h0, 4'b1111, rd, er, lat);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_clears got %h want 0", rd); end
  endtask

  task automatic test_error();
    logic [31:0] rd; logic er; int lat;
`ifdef DM_RESP_ERR_EN
    do_access(1'b1, 32'h1000, 32'h7, 4'b1111, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_range got %b want 1", er); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL err_lat got %0d want 3", lat); end
    do_access(1'b0, 32'h0, 32'h0, 4'b1111, rd, er, lat);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL err_noalias got %h want 0", rd); end
    do_access(1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, rd, er, lat);
    do_access(1'b1, 32'h22, 32'h12345678, 4'b1111, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_align got %b want 1", er); end
    do_access(1'b0, 32'h20, 32'h0, 4'b1111, rd, er, lat);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL err_unchanged got %h want cafef00d", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL err_ok_read got %b want 0", er); end
    do_access(1'b0, 32'h1000, 32'h0, 4'b1111, rd, er, lat);
    checks++; if (rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL err_read got %h/%b want 0/1", rd, er); end
`else
    do_access(1'b1, 32'h1000, 32'h7, 4'b1111, rd, er, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL alias_wr_err got %b want 0", er); end
    do_access(1'b0, 32'h0, 32'h0, 4'b1111, rd, er, lat);
    checks++; if (rd !== 32'h7) begin errors++; $display("FAIL alias_rd got %h want 7", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL alias_rd_err got %b want 0", er); end
`endif
  endtask

  task automatic test_back_to_back();
    logic        we_t [6]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ad_t [6]   = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8};
    logic [31:0] wd_t [6]   = '{32'hA5A5A5A5, 32'h01020304, 32'hFFFF0000, 32'h0, 32'h0, 32'h0};
    logic [31:0] exp_t [6]  = '{32'h0, 32'h0, 32'h0, 32'hA5A5A5A5, 32'h01020304, 32'hFFFF0000};
    int hs_t [6];
    int cyc, idx, rsp_n, bad_lat, bad_dat, bad_gap;
    logic hs;
    cyc = 0; idx = 0; rsp_n = 0; bad_lat = 0; bad_dat = 0; bad_gap = 0;
    rsp_ready0 = 1'b1;
    req_we0 = we_t[0]; req_addr0 = ad_t[0]; req_wdata0 = wd_t[0]; req_be0 = 4'hF;
    req_valid0 = 1'b1;
    for (int k = 0; k < 60 && rsp_n < 6; k++) begin
      hs = req_valid0 && req_ready0;
      @(posedge clk); #1;
      cyc++;
      if (hs && idx < 6) begin
        hs_t[idx] = cyc;
        idx++;
        if (idx < 6) begin
          req_we0 = we_t[idx]; req_addr0 = ad_t[idx]; req_wdata0 = wd_t[idx];
        end else begin
          req_valid0 = 1'b0;
        end
      end
      if (rsp_valid0 && rsp_n < idx) begin
        if (cyc - hs_t[rsp_n] != 1) bad_lat++;
        if (rsp_rdata0 !== exp_t[rsp_n]) bad_dat++;
        rsp_n++;
      end
    end
    req_valid0 = 1'b0;
    rsp_ready0 = 1'b0;
    for (int i = 1; i < idx; i++) if (hs_t[i] - hs_t[i-1] != 3) bad_gap++;
    checks++; if (rsp_n !== 6) begin errors++; $display("FAIL b2b_count got %0d want 6", rsp_n); end
    checks++; if (bad_lat !== 0) begin errors++; $display("FAIL b2b_latency got %0d bad want 0", bad_lat); end
    checks++; if (bad_dat !== 0) begin errors++; $display("FAIL b2b_data got %0d bad want 0", bad_dat); end
    checks++; if (bad_gap !== 0) begin errors++; $display("FAIL b2b_period got %0d bad want 0", bad_gap); end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lane();
    test_stall();
    test_reset_abort();
    test_error();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
